ch_switch_encoder: RTL and testbench

Sequential source-side front end for the switch/segment datapath. The block samples the eight raw slide-switch inputs CH7..CH0, synchronizes and debounces each one, and priority-encodes the stable switch bank into a 3-bit code plus an activity flag. Each new encoded value is delivered as one word over a valid/ready handshake to the downstream decode-and-display logic.

---
 rtl/ch_switch_encoder_if.sv | 21 ++
 rtl/ch_switch_encoder.sv | 135 +++++++++++++
 tb/tb_ch_switch_encoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ch_switch_encoder_if.sv
// Encoded-switch word channel: 3-bit code plus activity flag over a valid/ready handshake.
interface ch_switch_encoder_if;
  logic [2:0] code;
  logic       code_act;
  logic       code_valid;
  logic       code_ready;

  modport master (
    output code,
    output code_act,
    output code_valid,
    input  code_ready
  );

  modport slave (
    input  code,
    input  code_act,
    input  code_valid,
    output code_ready
  );
endinterface

// File: rtl/ch_switch_encoder.sv
// Slide-switch front end: 2-flop sync, per-channel debounce, priority encode,
// and change-only delivery of {act, code} words over valid/ready.
module ch_switch_encoder #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           ch_i,
  ch_switch_encoder_if.master  enc_o
);

  localparam int unsigned NCH    = 8;
  localparam int unsigned WORD_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  logic [NCH-1:0]    sync1_q, sync2_q;
  logic [NCH-1:0]    st_q, st_d;
  logic [CNT_W-1:0]  cnt_q [NCH];
  logic [CNT_W-1:0]  cnt_d [NCH];

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] last_q, last_d;
  logic              valid_q, valid_d;

  logic              enc_act_c;
  logic [2:0]        enc_code_c;
  logic [WORD_W-1:0] enc_word_c;

  // Two-flop synchronizer on the raw switch levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ch_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce: accept a level only after DEB_CYCLES consecutive differing samples
  for (genvar n = 0; n < NCH; n++) begin : g_deb
    always_comb begin
      st_d[n] = st_q[n];
      cnt_d[n] = cnt_q[n] + CNT_W'(1);
      if (sync2_q[n] == st_q[n]) begin
        cnt_d[n] = '0;
      end else if (cnt_q[n] == CNT_LAST) begin
        st_d[n]  = sync2_q[n];
        cnt_d[n] = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q[n]  <= 1'b0;
        cnt_q[n] <= '0;
      end else begin
        st_q[n]  <= st_d[n];
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  // Priority encoder over the stable bank, highest index wins
  always_comb begin
    enc_code_c = 3'd0;
    casez (st_q)
      8'b1???????: enc_code_c = 3'd7;
      8'b01??????: enc_code_c = 3'd6;
      8'b001?????: enc_code_c = 3'd5;
      8'b0001????: enc_code_c = 3'd4;
      8'b00001???: enc_code_c = 3'd3;
      8'b000001??: enc_code_c = 3'd2;
      8'b0000001?: enc_code_c = 3'd1;
      default:     enc_code_c = 3'd0;
    endcase
  end

  assign enc_act_c  = |st_q;
  assign enc_word_c = {enc_act_c, enc_code_c};

  // Delivery FSM; only the latest encoded value is compared after each acceptance
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (enc_word_c != last_q) begin
          word_d  = enc_word_c;
          valid_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (enc_o.code_ready) begin
          last_d  = word_q;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign enc_o.code       = word_q[2:0];
  assign enc_o.code_act   = word_q[3];
  assign enc_o.code_valid = valid_q;

endmodule

// File: tb/tb_ch_switch_encoder.sv
// Directed bench for ch_switch_encoder with a queue-based scoreboard on accepted words.
module tb_ch_switch_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ch;

  ch_switch_encoder_if bus();

  ch_switch_encoder #(.DEB_CYCLES(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ch_i  (ch),
    .enc_o (bus)
  );

  always #5 clk = ~clk;

  logic [2:0] code;
  logic       act;
  logic       valid;
  logic       ready;
  assign code  = bus.code;
  assign act   = bus.code_act;
  assign valid = bus.code_valid;
  assign bus.code_ready = ready;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_q [$];
  logic       prev_pend = 1'b0;
  logic [3:0] prev_word = 4'h0;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, actual, required, $time);
    end
  endtask

  // Monitor: pop and compare whenever a word is accepted; also checks hold-while-pending
  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst_n) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend)
        check("frozen", 8'({valid, act, code}), 8'({1'b1, prev_word}));
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 8'({act, code}), 8'hFF);
        end else begin
          e = exp_q.pop_front();
          check("word", 8'({act, code}), 8'(e));
        end
      end
      prev_pend = valid && !ready;
      prev_word = {act, code};
    end
  end

  task automatic wait_valid(input int max_cyc);
    int n = 0;
    while (!valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid", 8'(valid), 8'd1);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain", 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ch    = 8'h00;
    ready = 1'b1;

    // Reset state
    #12;
    check("reset_out", 8'({valid, act, code}), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("idle_quiet", 8'({valid, act, code}), 8'd0);
    end

    // Latency: CH2 captured at edge 0, valid for exactly the cycle after edge 6
    @(posedge clk); #1;
    ch[2] = 1'b1;
    exp_q.push_back(4'b1010);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("latency", 8'(valid), 8'(k == 6));
    end

    // 3-cycle glitch rejected
    @(posedge clk); #1;
    ch[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1 ch[2] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("reject", 8'(valid), 8'd0);
    end

    // 6-cycle low pulse: two words
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b1010);
    @(posedge clk); #1;
    ch[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1 ch[2] = 1'b1;
    drain(60);

    // Simultaneous settle: CH2 drops, CH1 and CH5 rise together -> one word
    @(posedge clk); #1;
    exp_q.push_back(4'b1101);
    ch = 8'b0010_0010;
    drain(40);
    @(posedge clk); #1;
    exp_q.push_back(4'b1001);
    ch = 8'b0000_0010;
    drain(40);
    repeat (10) @(negedge clk);

    // Backpressure with coalescing
    @(posedge clk); #1;
    ready = 1'b0;
    exp_q.push_back(4'b1101);
    exp_q.push_back(4'b1111);
    ch[5] = 1'b1;
    wait_valid(40);
    ch[7] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("hold", 8'({valid, act, code}), 8'b0001_1101);
    end
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk);
    check("gap", 8'(valid), 8'd0);
    @(negedge clk);
    check("next_word", 8'({valid, act, code}), 8'b0001_1111);
    @(posedge clk); #1;
    ready = 1'b1;
    drain(20);

    // Reset mid-SEND drops the pending word
    @(posedge clk); #1;
    ready = 1'b0;
    ch = 8'b0000_1000;
    wait_valid(40);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", 8'({valid, act, code}), 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'b1011);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_relatency", 8'(valid), 8'(k == 6));
    end
    @(posedge clk); #1;
    ready = 1'b1;
    drain(20);

    repeat (10) @(negedge clk);
    check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
